// File: rtl/word_symbol_pkg.sv
// Shared definitions for the 2-bit symbol link (transmit and receive ends).
package word_symbol_pkg;
  localparam int WORD_W     = 18;
  localparam int TAG_W      = 8;
  localparam int SYM_W      = 2;
  localparam int TAG_SYMS   = TAG_W / SYM_W;
  localparam int WORD_SYMS  = WORD_W / SYM_W;
  localparam int FRAME_SYMS = TAG_SYMS + WORD_SYMS + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAG,
    ST_DATA,
    ST_CHK
  } tx_state_t;
endpackage

// File: rtl/sym_xor_acc.sv
// Clearable, enable-gated XOR accumulator over link symbols; clear wins over enable.
module sym_xor_acc #(
  parameter int W = word_symbol_pkg::SYM_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] sym_i,
  output logic [W-1:0] acc_o
);
  logic [W-1:0] acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ sym_i;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/word_symbol_tx.sv
// Serialises tag+word into a framed, MSB-first 2-bit symbol stream closed by an XOR check symbol.
module word_symbol_tx #(
  parameter int WORD_W = word_symbol_pkg::WORD_W,
  parameter int TAG_W  = word_symbol_pkg::TAG_W,
  parameter int SYM_W  = word_symbol_pkg::SYM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_start,
  output logic              sym_end
);
  import word_symbol_pkg::*;

  localparam int N_TAG   = TAG_W / SYM_W;
  localparam int N_FRAME = N_TAG + WORD_W / SYM_W + 1;
  localparam int SR_W    = TAG_W + WORD_W;
  localparam int CNT_W   = $clog2(N_FRAME);

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_load_d;
  logic [SYM_W-1:0] sym_data_q;
  logic [SYM_W-1:0] acc_q;
  logic [SYM_W-1:0] chk_d;
  logic             sym_valid_q;
  logic             sym_start_q;
  logic             sym_end_q;
  logic             accept;
  logic             hs;
  logic             acc_en;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_CHK) & sym_ready);
  assign accept    = in_valid & in_ready;
  assign hs        = sym_valid_q & sym_ready;
  assign acc_en    = hs & ((state_q == ST_TAG) | (state_q == ST_DATA));
  assign sr_load_d = {in_tag, in_word};
  // Check symbol folds in the last word symbol as it is being handed over.
  assign chk_d     = acc_q ^ sym_data_q;

  sym_xor_acc #(.W(SYM_W)) u_acc (
    .clk   (clk),
    .reset (reset),
    .clr_i (accept),
    .en_i  (acc_en),
    .sym_i (sym_data_q),
    .acc_o (acc_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      sym_data_q  <= '0;
      sym_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
      sym_end_q   <= 1'b0;
    end else if (accept) begin
      // Also covers the CHK handshake that chains straight into the next frame.
      state_q     <= ST_TAG;
      cnt_q       <= '0;
      sr_q        <= {sr_load_d[SR_W-SYM_W-1:0], {SYM_W{1'b0}}};
      sym_data_q  <= sr_load_d[SR_W-1 -: SYM_W];
      sym_valid_q <= 1'b1;
      sym_start_q <= 1'b1;
      sym_end_q   <= 1'b0;
    end else if (hs) begin
      cnt_q       <= cnt_q + CNT_W'(1);
      sym_start_q <= 1'b0;
      case (state_q)
        ST_TAG, ST_DATA: begin
          if (cnt_q == CNT_W'(N_FRAME - 2)) begin
            state_q    <= ST_CHK;
            sym_data_q <= chk_d;
            sym_end_q  <= 1'b1;
          end else begin
            if (cnt_q == CNT_W'(N_TAG - 1)) state_q <= ST_DATA;
            sym_data_q <= sr_q[SR_W-1 -: SYM_W];
            sr_q       <= {sr_q[SR_W-SYM_W-1:0], {SYM_W{1'b0}}};
          end
        end
        ST_CHK: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          sym_data_q  <= '0;
          sym_valid_q <= 1'b0;
          sym_end_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign sym_start = sym_start_q;
  assign sym_end   = sym_end_q;
endmodule

// File: tb/tb_word_symbol_tx.sv
// Bench for word_symbol_tx: frames are predicted from tag/word arithmetic and compared symbol by symbol.
module tb_word_symbol_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_word;
  logic [7:0]  in_tag;
  logic        sym_valid;
  logic        sym_ready;
  logic [1:0]  sym_data;
  logic        sym_start;
  logic        sym_end;

  int checks = 0;
  int errors = 0;

  word_symbol_tx dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_tag    (in_tag),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .sym_start (sym_start),
    .sym_end   (sym_end)
  );

  always #5 clk = ~clk;

  logic [7:0]  pend_tag[$];
  logic [17:0] pend_word[$];
  logic [1:0]  exp_q[$];
  logic [1:0]  obs_sym[$];
  logic        obs_start[$];
  logic        obs_end[$];
  int          acc_hs[$];
  int          stall_viol, valid_cycles, gap_cycles, busy_rdy;
  bit          timeout;

  function automatic logic [1:0] exp_sym(input logic [7:0] t, input logic [17:0] w, input int k);
    logic [1:0] x;
    x = 2'b00;
    if (k < 4) return 2'((t >> (6 - 2 * k)) & 8'h03);
    if (k < 13) return 2'((w >> (16 - 2 * (k - 4))) & 18'h3);
    for (int j = 0; j < 13; j++) x = x ^ exp_sym(t, w, j);
    return x;
  endfunction

  function automatic void push_frame(input logic [7:0] t, input logic [17:0] w);
    pend_tag.push_back(t);
    pend_word.push_back(w);
    for (int k = 0; k < 14; k++) exp_q.push_back(exp_sym(t, w, k));
  endfunction

  // Drives all pending frames and records every symbol handshake plus stream statistics.
  task automatic run_stream(input int ready_mode, input int swap_hs, input int valid_pct);
    int         target, hs_cnt, cyc, phase, nacc;
    bit         started, prev_stall, hs, acc;
    logic [1:0] pd;
    logic       ps, pe;
    target = pend_tag.size() * 14;
    hs_cnt = 0; cyc = 0; phase = 0; nacc = 0;
    started = 0; prev_stall = 0; pd = 2'b00; ps = 1'b0; pe = 1'b0;
    obs_sym.delete(); obs_start.delete(); obs_end.delete(); acc_hs.delete();
    stall_viol = 0; valid_cycles = 0; gap_cycles = 0; busy_rdy = 0; timeout = 0;
    while (hs_cnt < target && !timeout) begin
      @(negedge clk);
      if (prev_stall && (sym_valid !== 1'b1 || sym_data !== pd || sym_start !== ps || sym_end !== pe))
        stall_viol++;
      case (ready_mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = started && (phase % 3 == 2);
        default: sym_ready = 1'($urandom_range(0, 1));
      endcase
      if (pend_tag.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        in_valid = 1'b1;
        if (nacc >= 1 && (hs_cnt % 14) < swap_hs) begin
          in_tag  = ~pend_tag[0];
          in_word = ~pend_word[0];
        end else begin
          in_tag  = pend_tag[0];
          in_word = pend_word[0];
        end
      end else begin
        in_valid = 1'b0;
        in_tag   = 8'($urandom);
        in_word  = 18'($urandom);
      end
      #1;
      if (sym_valid === 1'b1 && sym_end !== 1'b1 && in_ready === 1'b1) busy_rdy++;
      if (started) begin
        if (sym_valid === 1'b1) valid_cycles++;
        else gap_cycles++;
      end
      hs  = (sym_valid === 1'b1) && sym_ready;
      acc = in_valid && (in_ready === 1'b1);
      if (hs) begin
        obs_sym.push_back(sym_data);
        obs_start.push_back(sym_start);
        obs_end.push_back(sym_end);
        hs_cnt++;
      end
      if (started) phase++;
      if (acc) begin
        acc_hs.push_back(hs_cnt);
        nacc++;
        void'(pend_tag.pop_front());
        void'(pend_word.pop_front());
        started = 1;
      end
      prev_stall = (sym_valid === 1'b1) && !sym_ready;
      pd = sym_data; ps = sym_start; pe = sym_end;
      cyc++;
      if (cyc > 3000) timeout = 1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    sym_ready = 1'b0;
    pend_tag.delete();
    pend_word.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; sym_ready = 1'b0; in_tag = '0; in_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sym_valid); end
    checks++; if (sym_data !== 2'b00) begin errors++; $display("FAIL reset_data got %b want 00", sym_data); end
    checks++; if (sym_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", sym_start); end
    checks++; if (sym_end !== 1'b0) begin errors++; $display("FAIL reset_end got %b want 0", sym_end); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero_frame();
    logic [3:0] o, e;
    exp_q.delete();
    push_frame(8'h00, 18'h00000);
    run_stream(0, 0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL zero_timeout got %0d symbols want 14", obs_sym.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      o = {obs_sym[i], obs_start[i], obs_end[i]};
      e = {exp_q[i], i % 14 == 0, i % 14 == 13};
      checks++; if (o !== e) begin errors++; $display("FAIL zero_sym[%0d] got %b want %b", i, o, e); end
    end
    checks++; if (obs_sym[13] !== 2'b00) begin errors++; $display("FAIL zero_check got %b want 00", obs_sym[13]); end
    checks++; if (valid_cycles !== 14) begin errors++; $display("FAIL zero_cycles got %0d want 14", valid_cycles); end
  endtask

  task automatic test_a5_frame();
    logic [3:0] o, e;
    exp_q.delete();
    push_frame(8'hA5, 18'h3FFFF);
    run_stream(0, 0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL a5_timeout got %0d symbols want 14", obs_sym.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      o = {obs_sym[i], obs_start[i], obs_end[i]};
      e = {exp_q[i], i % 14 == 0, i % 14 == 13};
      checks++; if (o !== e) begin errors++; $display("FAIL a5_sym[%0d] got %b want %b", i, o, e); end
    end
    checks++; if (obs_sym[0] !== 2'b10) begin errors++; $display("FAIL a5_first got %b want 10", obs_sym[0]); end
    checks++; if (obs_sym[13] !== 2'b11) begin errors++; $display("FAIL a5_check got %b want 11", obs_sym[13]); end
  endtask

  task automatic test_stall_pattern();
    logic [3:0] o, e;
    exp_q.delete();
    push_frame(8'hA5, 18'h3FFFF);
    run_stream(1, 0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL stall_timeout got %0d symbols want 14", obs_sym.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      o = {obs_sym[i], obs_start[i], obs_end[i]};
      e = {exp_q[i], i % 14 == 0, i % 14 == 13};
      checks++; if (o !== e) begin errors++; $display("FAIL stall_sym[%0d] got %b want %b", i, o, e); end
    end
    checks++; if (valid_cycles !== 42) begin errors++; $display("FAIL stall_cycles got %0d want 42", valid_cycles); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_stability got %0d changes want 0", stall_viol); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] o, e;
    exp_q.delete();
    push_frame(8'($urandom), 18'($urandom));
    push_frame(8'($urandom), 18'($urandom));
    run_stream(0, 0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL b2b_timeout got %0d symbols want 28", obs_sym.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      o = {obs_sym[i], obs_start[i], obs_end[i]};
      e = {exp_q[i], i % 14 == 0, i % 14 == 13};
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_sym[%0d] got %b want %b", i, o, e); end
    end
    checks++; if (valid_cycles !== 28) begin errors++; $display("FAIL b2b_cycles got %0d want 28", valid_cycles); end
    checks++; if (gap_cycles !== 0) begin errors++; $display("FAIL b2b_gaps got %0d want 0", gap_cycles); end
    checks++; if (acc_hs.size() != 2 || acc_hs[1] !== 14) begin
      errors++; $display("FAIL b2b_accept_point got %0d want 14", acc_hs.size() > 1 ? acc_hs[1] : -1);
    end
    checks++; if (busy_rdy !== 0) begin errors++; $display("FAIL b2b_busy_ready got %0d want 0", busy_rdy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  t;
    logic [17:0] w;
    logic [3:0]  o, e;
    t = 8'($urandom); w = 18'($urandom);
    @(negedge clk);
    in_tag = t; in_word = w; in_valid = 1'b1; sym_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (sym_valid !== 1'b1 || sym_data !== exp_sym(t, w, 6)) begin
      errors++; $display("FAIL rst_mid_sym6 got %b/%b want 1/%b", sym_valid, sym_data, exp_sym(t, w, 6));
    end
    reset = 1'b1;
    #1;
    checks++; if ({sym_valid, sym_start, sym_end} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_async got %b want 000", {sym_valid, sym_start, sym_end});
    end
    @(negedge clk);
    sym_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    exp_q.delete();
    push_frame(8'($urandom), 18'($urandom));
    run_stream(0, 0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL rst_mid_timeout got %0d symbols want 14", obs_sym.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      o = {obs_sym[i], obs_start[i], obs_end[i]};
      e = {exp_q[i], i % 14 == 0, i % 14 == 13};
      checks++; if (o !== e) begin errors++; $display("FAIL rst_mid_sym[%0d] got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_valid_during_data();
    logic [3:0] o, e;
    exp_q.delete();
    push_frame(8'($urandom), 18'($urandom));
    push_frame(8'($urandom), 18'($urandom));
    run_stream(0, 10, 100);
    checks++; if (timeout) begin errors++; $display("FAIL busy_timeout got %0d symbols want 28", obs_sym.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      o = {obs_sym[i], obs_start[i], obs_end[i]};
      e = {exp_q[i], i % 14 == 0, i % 14 == 13};
      checks++; if (o !== e) begin errors++; $display("FAIL busy_sym[%0d] got %b want %b", i, o, e); end
    end
    checks++; if (busy_rdy !== 0) begin errors++; $display("FAIL busy_in_ready got %0d want 0", busy_rdy); end
    checks++; if (acc_hs.size() != 2 || acc_hs[1] !== 14) begin
      errors++; $display("FAIL busy_accept_point got %0d want 14", acc_hs.size() > 1 ? acc_hs[1] : -1);
    end
  endtask

  task automatic test_random();
    logic [3:0] o, e;
    for (int r = 0; r < 4; r++) begin
      exp_q.delete();
      for (int f = 0; f < 3; f++) push_frame(8'($urandom), 18'($urandom));
      run_stream(2, 0, 60);
      checks++; if (timeout) begin errors++; $display("FAIL rand%0d_timeout got %0d symbols want 42", r, obs_sym.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        o = {obs_sym[i], obs_start[i], obs_end[i]};
        e = {exp_q[i], i % 14 == 0, i % 14 == 13};
        checks++; if (o !== e) begin errors++; $display("FAIL rand%0d_sym[%0d] got %b want %b", r, i, o, e); end
      end
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL rand%0d_stability got %0d want 0", r, stall_viol); end
      checks++; if (busy_rdy !== 0) begin errors++; $display("FAIL rand%0d_busy_ready got %0d want 0", r, busy_rdy); end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    sym_ready = 1'b0;
    in_tag = '0;
    in_word = '0;
    test_reset();
    test_zero_frame();
    test_a5_frame();
    test_stall_pattern();
    test_back_to_back();
    test_reset_mid_frame();
    test_valid_during_data();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_symbol_tx.md
# word_symbol_tx

Transmit end of the 2-bit symbol link: accepts one 18-bit word plus an 8-bit tag per handshake and serialises it, MSB first, into a framed stream of 2-bit symbols ending in a check symbol. Sits between a word-level producer and the narrow symbol lane consumed by the matching receiver (`word_symbol_rx`). Supports back-to-back frames with no idle symbol between them.

## Interface
Parameters:
- `WORD_W`, 18, payload word width; must be a multiple of `SYM_W`.
- `TAG_W`, 8, tag width; must be a multiple of `SYM_W`.
- `SYM_W`, 2, symbol width.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  block accepts word this cycle
- `in_word`  in  `WORD_W`  payload
- `in_tag`  in  `TAG_W`  tag
- `sym_valid`  out  1  symbol present
- `sym_ready`  in  1  consumer takes symbol
- `sym_data`  out  `SYM_W`  symbol
- `sym_start`  out  1  first symbol of frame
- `sym_end`  out  1  last (check) symbol of frame

## Operation
- Frame = `TAG_W/SYM_W` tag symbols (4), then `WORD_W/SYM_W` word symbols (9), then 1 check symbol: 14 symbols total.
- Tag and word are sent MSB-first: tag[7:6], tag[5:4], ..., word[17:16], ..., word[1:0].
- Check symbol = XOR of all 13 preceding symbols of the frame.
- FSM states: IDLE, TAG, DATA, CHK.
  - IDLE -> TAG on accept.
  - TAG -> DATA after the 4th tag symbol handshake.
  - DATA -> CHK after the 9th word symbol handshake.
  - CHK -> TAG on check-symbol handshake if a new word is accepted in the same cycle; otherwise CHK -> IDLE.
- A symbol index counter (0..13) and a running XOR accumulator are cleared at frame accept. The accumulator updates on each data/tag symbol handshake.
- Tag and word are captured into a shift register at accept; the producer inputs are not used after the accept cycle.
- `in_ready = (state==IDLE) | (state==CHK & sym_ready)`. Combinational from `sym_ready`; all other outputs are registered.
- `sym_start` is high only with tag symbol 0. `sym_end` is high only with the check symbol.
- Reset values: `sym_valid`=0, `sym_data`=0, `sym_start`=0, `sym_end`=0, state IDLE, counter 0, accumulator 0. `in_ready`=1 when reset is deasserted.
- Reset mid-frame abandons the frame immediately: `sym_valid` drops asynchronously and no check symbol is sent. The receiver resynchronises on the next `sym_start`.

## Timing
- Accept at edge N -> `sym_valid`=1 with tag symbol 0 and `sym_start`=1 from edge N onward (visible in cycle N+1).
- Each symbol handshake (`sym_valid & sym_ready` at an edge) presents the next symbol after that edge.
- While `sym_valid & !sym_ready`, `sym_data`, `sym_start` and `sym_end` hold stable, and `sym_valid` does not drop.
- With `sym_ready` held at 1: 14 cycles per frame. Back-to-back frames give a continuous stream, with the next frame's `sym_start` directly after `sym_end`.
- `in_valid` with `in_ready`=0 is ignored. The producer must hold its data until accepted.

## Structure
- Shared package `word_symbol_pkg`: `WORD_W`, `TAG_W`, `SYM_W`, derived `TAG_SYMS`, `WORD_SYMS`, `FRAME_SYMS`, and the state enum `tx_state_t`. This package is shared with `word_symbol_rx`.
- One natural sub-module: `sym_xor_acc`, the clearable, enable-gated `SYM_W` XOR accumulator. It is reused by the receiver for checking.

## Test plan
- Tag 0x00, word 0x00000, `sym_ready`=1 -> 14 symbols of 00; `sym_start` on symbol 0, `sym_end` on symbol 13; check symbol 00.
- Tag 0xA5, word 0x3FFFF -> tag symbols 10,10,01,01; word symbols 9×11; check symbol 11.
- Same frame with `sym_ready` toggling in a 1-0-0 pattern -> identical symbol sequence; outputs stable during every stall; 42 cycles total.
- Two words presented back-to-back with `in_valid` held, `sym_ready`=1 -> `in_ready` pulses on the CHK handshake; 28 consecutive valid symbols with no gap.
- Reset asserted after the 6th symbol handshake -> `sym_valid`/`sym_start`/`sym_end`=0 immediately; after release `in_ready`=1; next frame starts cleanly with a correct check symbol.
- `in_valid` asserted during DATA -> not accepted; producer data is captured only at the CHK handshake or in IDLE.
